// File: rtl/display_scan_driver.sv
// Display scan driver for an 8-digit multiplexed seven-segment display.
// Captures a 32-bit display word whenever it (or the mode) changes. Hex mode shows all
// eight nibbles. Decimal mode converts bin[15:0] to five BCD digits with a sequential
// shift-add-3 engine and blanks the top three digits. The digits are scanned
// continuously, one slot every COUNT_MAX clocks.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   i_bin  - value to display (hex: digit k = i_bin[4k+3:4k])
//   i_mode - 0 = hex, 1 = decimal of i_bin[15:0]
//   o_an   - digit anodes, active-low, o_an[7] = leftmost digit
//   o_seg  - segments, active-low, {g,f,e,d,c,b,a}
//   o_busy - high while a capture is in progress (SHIFT or COMMIT)
module display_scan_driver #(
  parameter int unsigned COUNT_MAX = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_bin,
  input  logic        i_mode,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_busy
);

  localparam int unsigned CntW = $clog2(COUNT_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'(COUNT_MAX - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e          state_q, state_d;
  logic [32:0]     last_q, last_d;      // {mode, bin} last captured
  logic [32:0]     shadow_q, shadow_d;  // {mode, bin} being processed
  logic [35:0]     shift_q, shift_d;    // {bcd[19:0], bin[15:0]}
  logic [3:0]      iter_q, iter_d;
  logic [31:0]     disp_q, disp_d;
  logic [7:0]      blank_q, blank_d;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [35:0]     adj;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Add-3 correction on the five BCD nibbles ahead of each shift.
  always_comb begin
    adj = shift_q;
    for (int n = 0; n < 5; n++) begin
      if (shift_q[16+4*n +: 4] >= 4'd5) begin
        adj[16+4*n +: 4] = shift_q[16+4*n +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    shift_d  = shift_q;
    iter_d   = iter_q;
    disp_d   = disp_q;
    blank_d  = blank_q;
    unique case (state_q)
      StIdle: begin
        if ({i_mode, i_bin} != last_q) begin
          last_d   = {i_mode, i_bin};
          shadow_d = {i_mode, i_bin};
          if (i_mode) begin
            shift_d = {20'b0, i_bin[15:0]};
            iter_d  = 4'd0;
            state_d = StShift;
          end else begin
            state_d = StCommit;
          end
        end
      end
      StShift: begin
        shift_d = {adj[34:0], 1'b0};
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (shadow_q[32]) begin
          disp_d  = {12'b0, shift_q[35:16]};
          blank_d = 8'hE0;
        end else begin
          disp_d  = shadow_q[31:0];
          blank_d = 8'h00;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= '0;
      shadow_q <= '0;
      shift_q  <= '0;
      iter_q   <= '0;
      disp_q   <= '0;
      blank_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      iter_q   <= iter_d;
      disp_q   <= disp_d;
      blank_q  <= blank_d;
    end
  end

  // Refresh scan runs independently of the capture FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    if (blank_q[idx_q]) begin
      o_an  = 8'hFF;
      o_seg = 7'h7F;
    end else begin
      o_an  = ~(8'd1 << idx_q);
      o_seg = hex_seg(disp_q[{idx_q, 2'b00} +: 4]);
    end
  end

  assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_display_scan_driver.sv
module tb_display_scan_driver;
  localparam int unsigned CM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_bin = '0;
  logic        i_mode = 1'b0;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_busy;

  always #5 clk = ~clk;

  display_scan_driver #(.COUNT_MAX(CM)) dut (
    .clk   (clk),
    .reset (reset),
    .i_bin (i_bin),
    .i_mode(i_mode),
    .o_an  (o_an),
    .o_seg (o_seg),
    .o_busy(o_busy)
  );

  int total = 0;
  int bad = 0;

  // Reference slot position: which digit the scan should be on.
  int       m_cnt;
  logic [2:0] m_idx;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_idx <= '0;
    end else if (m_cnt == CM - 1) begin
      m_cnt <= 0;
      m_idx <= m_idx + 3'd1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] bin;
    logic        mode;
    int          busy;
    logic [31:0] disp;
    logic [7:0]  mask;
  } vec_t;

  vec_t        vecs[6];
  logic [14:0] exp_q[$];
  logic [31:0] prev_disp;
  logic [7:0]  prev_mask;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [14:0] exp_pair(input logic [31:0] d, input logic [7:0] m,
                                           input int i);
    logic [3:0] nb;
    nb = d[4*i +: 4];
    if (m[i]) return {8'hFF, 7'h7F};
    return {~(8'd1 << i), seg_of(nb)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_busy) break;
      n++;
    end
  endtask

  // Nine slots so the 7 -> 0 wrap is also covered.
  task automatic check_scan(input logic [31:0] d, input logic [7:0] m, input string tag);
    logic [14:0] e;
    int w;
    for (int s = 0; s < 9; s++) exp_q.push_back(exp_pair(d, m, s % 8));
    for (int s = 0; s < 9; s++) begin
      w = 0;
      @(negedge clk);
      while (m_idx != 3'(s % 8) && w < 40) begin
        @(negedge clk);
        w++;
      end
      e = exp_q.pop_front();
      if (w >= 40) begin
        total++;
        bad++;
        $display("FAIL %s slot%0d timeout: got none want %0h", tag, s, e);
      end else begin
        check($sformatf("%s slot%0d", tag, s), 32'({o_an, o_seg}), 32'(e));
      end
    end
  endtask

  initial begin
    int n;
    int hi;

    vecs[0] = '{32'h1234ABCD, 1'b0, 1,  32'h1234ABCD, 8'h00};
    vecs[1] = '{32'h0000FFFF, 1'b1, 17, 32'h00065535, 8'hE0};
    vecs[2] = '{32'h00000000, 1'b1, 17, 32'h00000000, 8'hE0};
    vecs[3] = '{32'h00002719, 1'b1, 17, 32'h00010009, 8'hE0};
    vecs[4] = '{32'h55552719, 1'b1, 17, 32'h00010009, 8'hE0};
    vecs[5] = '{32'h89EF0567, 1'b0, 1,  32'h89EF0567, 8'h00};

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("reset an", 32'(o_an), 32'hFE);
    check("reset seg", 32'(o_seg), 32'h40);
    check("reset busy", 32'(o_busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_busy) hi++;
    end
    check("no busy after reset", 32'(hi), 32'h0);

    for (int v = 0; v < 6; v++) begin
      i_bin  = vecs[v].bin;
      i_mode = vecs[v].mode;
      measure_busy(n);
      check($sformatf("v%0d busy cycles", v), 32'(n), 32'(vecs[v].busy));
      check_scan(vecs[v].disp, vecs[v].mask, $sformatf("v%0d", v));
    end
    prev_disp = vecs[5].disp;
    prev_mask = vecs[5].mask;

    // Change while busy: 1234 is committed, 42 follows one idle cycle later.
    i_bin  = 32'd1234;
    i_mode = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_busy) break;
      n++;
      if (i == 4) i_bin = 32'd42;
      if (i == 15) begin
        check("hold before commit", 32'({o_an, o_seg}),
              32'(exp_pair(prev_disp, prev_mask, int'(m_idx))));
      end
    end
    check("busy1234 cycles", 32'(n), 32'd17);
    check("commit 01234", 32'({o_an, o_seg}), 32'(exp_pair(32'h00001234, 8'hE0, int'(m_idx))));
    measure_busy(n);
    check("busy42 cycles", 32'(n), 32'd17);
    check_scan(32'h00000042, 8'hE0, "late42");

    // Reset mid-conversion.
    i_bin = 32'd777;
    repeat (9) @(negedge clk);
    check("busy before abort", 32'(o_busy), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("abort busy", 32'(o_busy), 32'h0);
    check("abort display", 32'({o_an, o_seg}), 32'({8'hFE, 7'h40}));
    @(negedge clk);
    reset = 1'b0;
    measure_busy(n);
    check("busy777 cycles", 32'(n), 32'd17);
    check_scan(32'h00000777, 8'hE0, "d777");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
